// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: word/half/byte loads and stores with RMW sub-word stores.
// Optional DM_ALIGN_CHECK_EN flags and suppresses misaligned accesses.
module dm_access_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              HalfAndByte,
    input  logic              Byte,
    input  logic              Half,
    input  logic              unsign,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              align_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [2:0] {
        IDLE, RD, WR, RMW_RD, RMW_WR, DONE
    } state_e;

    state_e      state_q;
    logic [1:0]  addr_q;
    logic [15:0] wdata_q;
    logic        hab_q;
    logic        byte_q;
    logic        unsign_q;

    logic        req;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic        addr_unused;

    assign req = MemRead | MemWrite;
    assign addr_unused = ^addr[31:ADDR_W+2];

`ifdef DM_ALIGN_CHECK_EN
    // Bytes can never be misaligned; halfwords need addr[0]=0, words addr[1:0]=0.
    assign align_err = (state_q == IDLE) && req &&
                       (HalfAndByte ? (Half && addr[0])
                                    : (addr[1:0] != 2'b00));
`else
    logic kind_unused;
    assign kind_unused = Half;
    assign align_err = 1'b0;
`endif

    assign stall = ((state_q == IDLE) && req && !align_err) ||
                   ((state_q != IDLE) && (state_q != DONE));

    always_comb begin
        lane_b   = mem_rdata[{addr_q, 3'b000} +: 8];
        lane_h   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_val = mem_rdata;
        if (hab_q) begin
            if (byte_q)
                load_val = {{24{~unsign_q & lane_b[7]}}, lane_b};
            else
                load_val = {{16{~unsign_q & lane_h[15]}}, lane_h};
        end
        merged = mem_rdata;
        if (byte_q)
            merged[{addr_q, 3'b000} +: 8] = wdata_q[7:0];
        else if (addr_q[1])
            merged[31:16] = wdata_q;
        else
            merged[15:0] = wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            hab_q     <= 1'b0;
            byte_q    <= 1'b0;
            unsign_q  <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req && !align_err) begin
                        addr_q   <= addr[1:0];
                        wdata_q  <= wdata[15:0];
                        hab_q    <= HalfAndByte;
                        byte_q   <= Byte;
                        unsign_q <= unsign;
                        mem_req  <= 1'b1;
                        mem_addr <= addr[ADDR_W+1:2];
                        if (MemRead) begin
                            state_q <= RD;
                            mem_we  <= 1'b0;
                        end else if (!HalfAndByte) begin
                            state_q   <= WR;
                            mem_we    <= 1'b1;
                            mem_wdata <= wdata;
                        end else begin
                            state_q <= RMW_RD;
                            mem_we  <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        rdata   <= load_val;
                        mem_req <= 1'b0;
                        state_q <= DONE;
                    end
                end
                WR, RMW_WR: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                RMW_RD: begin
                    // mem_wdata doubles as the merge register for the write-back.
                    if (mem_ack) begin
                        mem_wdata <= merged;
                        mem_we    <= 1'b1;
                        state_q   <= RMW_WR;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed testbench for dm_access_ctrl with a handshaked word memory model.
// Build with DM_ALIGN_CHECK_EN to exercise the misalignment path.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, HalfAndByte, Byte, Half, unsign;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, align_err;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_delay = 0;
    int wcnt = 0;
    int ncyc;
    bit mem_loaded = 1'b0;
    bit [31:0] mem [1024];

    dm_access_ctrl #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .HalfAndByte(HalfAndByte), .Byte(Byte), .Half(Half),
        .unsign(unsign), .addr(addr), .wdata(wdata),
        .rdata(rdata), .stall(stall), .align_err(align_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            mem[0] = 32'h8001_1234;
            mem[1] = 32'h8899_AABB;
            mem[2] = 32'h1122_3344;
            mem_loaded = 1'b1;
        end else if (mem_req && mem_ack && mem_we && !rst) begin
            mem[mem_addr] = mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_req) begin
            if (wcnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                wcnt      = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic hab,
                          input logic byt, input logic hf, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int cyc);
        MemRead = rd; MemWrite = wr; HalfAndByte = hab;
        Byte = byt; Half = hf; unsign = uns; addr = a; wdata = wd;
        #1;
        cyc = 0;
        while (stall && cyc < 40) begin
            if (mem_req) begin
                chk("mem_addr", {22'b0, mem_addr}, {22'b0, a[11:2]});
                if (!hab) chk("mem_we", {31'b0, mem_we}, {31'b0, wr});
                if (!hab && wr) chk("mem_wdata", mem_wdata, wd);
            end
            cyc++;
            @(negedge clk); #1;
        end
        chk("no_timeout", {31'b0, cyc < 40}, 32'd1);
        chk("done_req_low", {31'b0, mem_req}, 32'd0);
        MemRead = 0; MemWrite = 0; HalfAndByte = 0;
        Byte = 0; Half = 0; unsign = 0;
        @(negedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        MemRead = 0; MemWrite = 0; HalfAndByte = 0;
        Byte = 0; Half = 0; unsign = 0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_maddr", {22'b0, mem_addr}, 32'd0);
        chk("rst_mwdata", mem_wdata, 32'h0);
        chk("rst_align", {31'b0, align_err}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        rst = 1'b0;
        @(negedge clk); #1;

        access(1, 0, 1, 1, 0, 0, 32'h6, 32'h0, ncyc);
        chk("lb_rdata", rdata, 32'hFFFF_FF99);
        chk("lb_stall", ncyc, 32'd2);

        access(1, 0, 1, 1, 0, 1, 32'h6, 32'h0, ncyc);
        chk("lbu_rdata", rdata, 32'h0000_0099);
        chk("lbu_stall", ncyc, 32'd2);

        access(1, 0, 1, 0, 1, 0, 32'h6, 32'h0, ncyc);
        chk("lh_rdata", rdata, 32'hFFFF_8899);

        access(1, 0, 1, 0, 1, 1, 32'h4, 32'h0, ncyc);
        chk("lhu_rdata", rdata, 32'h0000_AABB);

        access(0, 1, 1, 0, 1, 0, 32'hA, 32'h0000_BEEF, ncyc);
        chk("sh_mem", mem[2], 32'hBEEF_3344);
        chk("sh_stall", ncyc, 32'd3);
        chk("sh_rdata_kept", rdata, 32'h0000_AABB);

        access(0, 1, 1, 1, 0, 0, 32'h7, 32'h0000_0055, ncyc);
        chk("sb_mem", mem[1], 32'h5599_AABB);

        ack_delay = 2;
        access(0, 1, 0, 0, 0, 0, 32'h10, 32'hDEAD_BEEF, ncyc);
        chk("sw_mem", mem[4], 32'hDEAD_BEEF);
        chk("sw_stall", ncyc, 32'd4);
        ack_delay = 0;

        access(1, 0, 0, 0, 0, 0, 32'h10, 32'h0, ncyc);
        chk("lw_rdata", rdata, 32'hDEAD_BEEF);
        chk("lw_stall", ncyc, 32'd2);

`ifdef DM_ALIGN_CHECK_EN
        MemRead = 1; HalfAndByte = 1; Half = 1; addr = 32'h3;
        #1;
        chk("mis_align", {31'b0, align_err}, 32'd1);
        chk("mis_stall", {31'b0, stall}, 32'd0);
        @(negedge clk); #1;
        chk("mis_noreq", {31'b0, mem_req}, 32'd0);
        chk("mis_rdata", rdata, 32'hDEAD_BEEF);
        MemRead = 0; HalfAndByte = 0; Half = 0;
        @(negedge clk); #1;
`else
        access(1, 0, 1, 0, 1, 0, 32'h3, 32'h0, ncyc);
        chk("lh3_rdata", rdata, 32'hFFFF_8001);
        chk("lh3_align", {31'b0, align_err}, 32'd0);
`endif

        ack_delay = 3;
        MemWrite = 1; HalfAndByte = 1; Half = 1;
        addr = 32'hA; wdata = 32'h0000_CAFE;
        @(negedge clk); #1;
        chk("rmw_req", {31'b0, mem_req}, 32'd1);
        rst = 1'b1;
        MemWrite = 0; HalfAndByte = 0; Half = 0;
        @(negedge clk); #1;
        chk("rstmid_req", {31'b0, mem_req}, 32'd0);
        chk("rstmid_stall", {31'b0, stall}, 32'd0);
        chk("rstmid_rdata", rdata, 32'h0);
        rst = 1'b0;
        ack_delay = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rstmid_mem", mem[2], 32'hBEEF_3344);

        access(1, 0, 0, 0, 0, 0, 32'h8, 32'h0, ncyc);
        chk("post_rst_lw", rdata, 32'hBEEF_3344);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Data-memory access controller sitting directly downstream of the control unit and ALU in the SCPU datapath. It consumes the memory-control decode (MemRead, MemWrite, HalfAndByte, Byte, Half, unsign), the ALU effective address and the rt store data. It runs word, halfword and byte loads and stores against a word-wide handshaked memory, using read-modify-write for sub-word stores. While an access is in flight it stalls the single-cycle core.

## Interface
- ADDR_W, 10: word-address width of the memory port; mem_addr = addr[ADDR_W+1:2].
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- MemRead  in  1  load request (lb/lbu/lh/lhu/lw).
- MemWrite  in  1  store request (sb/sh/sw).
- HalfAndByte  in  1  sub-word access.
- Byte  in  1  byte access.
- Half  in  1  halfword access.
- unsign  in  1  zero-extend (1) or sign-extend (0) sub-word loads.
- addr  in  32  byte address from ALU.
- wdata  in  32  store data (rt).
- rdata  out  32  load result, extended, registered.
- stall  out  1  hold PC and register-file write while high.
- align_err  out  1  misaligned access flag (see Configuration).
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 write, 0 read; stable while mem_req.
- mem_addr  out  ADDR_W  word address; stable while mem_req.
- mem_wdata  out  32  write word; stable while mem_req.
- mem_rdata  in  32  read word, valid when mem_ack.
- mem_ack  in  1  memory completion, sampled at the clock edge while mem_req is high.

## Operation
- Reset values: state IDLE, rdata 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, align_err 0. Internal latches for address, data and kind also clear to 0.
- Little-endian lanes: byte lane addr[1:0] (lane 0 = bits 7:0); half lane addr[1] (lane 0 = bits 15:0).
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
- IDLE leaving on a request:
  - Latch addr, wdata and the kind bits on exit.
  - MemRead goes to RD; it wins over MemWrite if both are high, which is illegal from the CU.
  - MemWrite with !HalfAndByte goes to WR.
  - MemWrite with HalfAndByte goes to RMW_RD.
  - No request: stay in IDLE.
- RD: mem_req=1, mem_we=0. On ack, capture the extracted, extended lane into rdata and go to DONE.
- WR: mem_req=1, mem_we=1, mem_wdata = latched wdata. On ack go to DONE.
- RMW_RD: read the word. On ack, merge wdata[7:0] (byte) or wdata[15:0] (half) into the selected lane, hold the result in the merge register, and go to RMW_WR.
- RMW_WR: write the merged word. On ack go to DONE.
- DONE: mem_req=0, stall=0 for exactly one cycle, then unconditionally IDLE. The pending instruction retires in this cycle, so there is no re-trigger.
- stall = (IDLE & (MemRead|MemWrite) & !align_err) | (state ∉ {IDLE, DONE}).
- rdata holds its value until the next load completes; stores never modify it.
- Extension: lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes through.

## Timing
- mem_req, mem_we, mem_addr and mem_wdata are registered, derived from state and latches. mem_req rises the cycle after IDLE detects a request.
- Zero-wait memory (ack in the first req cycle):
  - Load or word store: 3 cycles total, stall high for 2.
  - Sub-word store: 4 cycles total, stall high for 3.
- Each extra wait cycle before ack adds one cycle per memory transaction.
- mem_req drops in the cycle after the ack edge. There are never back-to-back req cycles without an intervening state transition.
- Back-to-back memory instructions: DONE → IDLE → new access. There is one non-stalled IDLE detect cycle; the IDLE cycle of the second access is itself stalled.
- rst mid-operation: at the next edge the FSM goes to IDLE and mem_req goes to 0. No write completes after reset is sampled. The memory must tolerate req being withdrawn.

## Configuration
- DM_ALIGN_CHECK_EN defined:
  - align_err is high combinationally in IDLE for lw/sw with addr[1:0]≠0, and for lh/lhu/sh with addr[0]≠0.
  - The access is suppressed: no mem_req, stall=0, rdata unchanged.
- Undefined: align_err is tied 0. Offending low address bits are ignored; lw/sw use addr[1:0]=0 and halfwords use addr[0]=0.

## Test plan
- Memory word 0x1 = 0x8899AABB, zero-wait; lb addr 0x6 → rdata 0xFFFFFF99 after 3 cycles; lbu addr 0x6 → 0x00000099.
- Word 0x2 = 0x11223344; sh addr 0xA, wdata 0x0000BEEF → RMW sequence writes 0xBEEF3344; stall high for exactly 3 cycles.
- sw addr 0x10, wdata 0xDEADBEEF, ack delayed 2 cycles → mem_addr 4, mem_we 1 held stable; stall high for 4 cycles; then lw addr 0x10 → 0xDEADBEEF.
- rst asserted during RMW_RD → next cycle state IDLE, mem_req 0, rdata 0; target word unchanged.
- With DM_ALIGN_CHECK_EN: lh addr 0x3 → align_err 1, stall 0, no mem_req. Without it: same access reads lane 1 of word 0, bits 31:16, sign-extended.
